// File: rtl/systolic_pe_mac_if.sv
// Operand, forwarding and result signals of one systolic PE.
// slave is the PE side; master is the surrounding array / test environment.
interface systolic_pe_mac_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned ACCW = 32,
  parameter int unsigned LENW = 8
);
  logic            start;
  logic [LENW-1:0] len;
  logic            west_rv;
  logic [DW-1:0]   west_dat;
  logic            west_re;
  logic            north_rv;
  logic [DW-1:0]   north_dat;
  logic            north_re;
  logic            east_ff;
  logic            east_we;
  logic [DW-1:0]   east_dat;
  logic            south_ff;
  logic            south_we;
  logic [DW-1:0]   south_dat;
  logic            busy;
  logic            res_valid;
  logic [ACCW-1:0] res_data;
  logic            res_ack;

  modport slave (
    input  start, len, west_rv, west_dat, north_rv, north_dat, east_ff, south_ff, res_ack,
    output west_re, north_re, east_we, east_dat, south_we, south_dat, busy, res_valid,
           res_data
  );

  modport master (
    output start, len, west_rv, west_dat, north_rv, north_dat, east_ff, south_ff, res_ack,
    input  west_re, north_re, east_we, east_dat, south_we, south_dat, busy, res_valid,
           res_data
  );
endinterface

// File: rtl/systolic_pe_mac.sv
// Systolic PE: pops paired west/north operands, forwards them east/south and
// accumulates their signed product over len steps into a hold-until-ack result.
module systolic_pe_mac #(
  parameter int unsigned DW   = 16,
  parameter int unsigned ACCW = 32,
  parameter int unsigned LENW = 8
) (
  input logic               clk,
  input logic               rst_n,
  systolic_pe_mac_if.slave  io_bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 r_state;
  logic [ACCW-1:0]        r_acc;
  logic [LENW-1:0]        r_cnt;
  logic [LENW-1:0]        r_len;
  logic                   r_busy;
  logic                   r_res_valid;
  logic                   r_east_we;
  logic                   r_south_we;
  logic [DW-1:0]          r_east_dat;
  logic [DW-1:0]          r_south_dat;

  logic                   w_fire;
  logic [LENW:0]          w_cnt_inc;
  logic                   w_last;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_ext;

  // start wins over a same-cycle fire, so no operand is popped into an aborted tile
  always_comb begin
    w_fire = (r_state == StRun) & io_bus.west_rv & io_bus.north_rv &
             ~io_bus.east_ff & ~io_bus.south_ff & ~io_bus.start;
  end

  // One extra bit keeps len = 2^LENW-1 from wrapping before the compare
  always_comb begin
    w_cnt_inc  = {1'b0, r_cnt} + (LENW + 1)'(1);
    w_last     = w_fire & (w_cnt_inc == {1'b0, r_len});
    w_prod     = $signed(io_bus.west_dat) * $signed(io_bus.north_dat);
    w_prod_ext = ACCW'(w_prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_east_we   <= 1'b0;
      r_south_we  <= 1'b0;
      r_east_dat  <= '0;
      r_south_dat <= '0;
    end else begin
      r_east_we  <= w_fire;
      r_south_we <= w_fire;
      if (io_bus.start) begin
        r_len       <= io_bus.len;
        r_cnt       <= '0;
        r_acc       <= '0;
        r_busy      <= 1'b1;
        if (io_bus.len == '0) begin
          r_state     <= StDone;
          r_res_valid <= 1'b1;
        end else begin
          r_state     <= StRun;
          r_res_valid <= 1'b0;
        end
      end else begin
        unique case (r_state)
          StIdle: ;
          StRun: begin
            if (w_fire) begin
              r_acc       <= r_acc + w_prod_ext;
              r_cnt       <= w_cnt_inc[LENW-1:0];
              r_east_dat  <= io_bus.west_dat;
              r_south_dat <= io_bus.north_dat;
              if (w_last) begin
                r_state     <= StDone;
                r_res_valid <= 1'b1;
              end
            end
          end
          StDone: begin
            if (io_bus.res_ack) begin
              r_state     <= StIdle;
              r_res_valid <= 1'b0;
              r_busy      <= 1'b0;
            end
          end
          default: begin
            r_state     <= StIdle;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_bus.west_re   = w_fire;
  assign io_bus.north_re  = w_fire;
  assign io_bus.east_we   = r_east_we;
  assign io_bus.south_we  = r_south_we;
  assign io_bus.east_dat  = r_east_dat;
  assign io_bus.south_dat = r_south_dat;
  assign io_bus.busy      = r_busy;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_data  = r_acc;

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Randomised self-checking bench for systolic_pe_mac against a FIFO-queue
// model that sums signed products of popped operand pairs.
module tb_systolic_pe_mac;
  localparam int unsigned DW   = 16;
  localparam int unsigned ACCW = 32;
  localparam int unsigned LENW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_pe_mac_if #(.DW(DW), .ACCW(ACCW), .LENW(LENW)) bus ();

  systolic_pe_mac #(.DW(DW), .ACCW(ACCW), .LENW(LENW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int              n_checks = 0;
  int              n_errs   = 0;
  logic [DW-1:0]   qa[$];
  logic [DW-1:0]   qb[$];
  logic [ACCW-1:0] last_res;
  int              last_pops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ACCW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[ACCW-1:0];
  endfunction

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.west_rv   = 1'b0;
    bus.west_dat  = '0;
    bus.north_rv  = 1'b0;
    bus.north_dat = '0;
    bus.east_ff   = 1'b0;
    bus.south_ff  = 1'b0;
    bus.res_ack   = 1'b0;
  endtask

  task automatic fill_random(input int n);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(DW'($urandom));
      qb.push_back(DW'($urandom));
    end
  endtask

  task automatic present_heads(input bit rvw, input bit rvn);
    bus.west_rv   = rvw && (qa.size() > 0);
    bus.north_rv  = rvn && (qb.size() > 0);
    bus.west_dat  = (qa.size() > 0) ? qa[0] : DW'($urandom);
    bus.north_dat = (qb.size() > 0) ? qb[0] : DW'($urandom);
  endtask

  // mode: 0 always ready, 1 random stalls, 2 east_ff high in RUN cycles 2-5,
  // 3 north_rv low for the first 3 RUN cycles. abort_after>0 returns mid-tile.
  task automatic run_tile(input int len, input int mode, input int abort_after);
    int              pops = 0;
    int              dut_pops = 0;
    int              k = 0;
    int              hold;
    bit              done;
    bit              exp_we = 1'b0;
    bit              exp_re;
    bit              rvw, rvn, ffe, ffs;
    logic [DW-1:0]   exp_e = '0;
    logic [DW-1:0]   exp_s = '0;
    logic [ACCW-1:0] acc = '0;

    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.len      = LENW'(len);
    bus.east_ff  = 1'b0;
    bus.south_ff = 1'b0;
    bus.res_ack  = 1'b0;
    present_heads(1'b1, 1'b1);
    @(negedge clk);
    check("start_no_pop", bus.west_re, 1'b0);
    done = (len == 0);

    while (k < 3000) begin
      k++;
      @(posedge clk); #1;
      bus.start = 1'b0;
      rvw = 1'b1; rvn = 1'b1; ffe = 1'b0; ffs = 1'b0;
      case (mode)
        1: begin
          rvw = ($urandom_range(0, 99) < 75);
          rvn = ($urandom_range(0, 99) < 75);
          ffe = ($urandom_range(0, 99) < 15);
          ffs = ($urandom_range(0, 99) < 15);
        end
        2: ffe = (k >= 2 && k <= 5);
        3: rvn = (k > 3);
        default: ;
      endcase
      present_heads(rvw, rvn);
      rvw = bus.west_rv;
      rvn = bus.north_rv;
      bus.east_ff  = ffe;
      bus.south_ff = ffs;
      @(negedge clk);
      exp_re = !done && rvw && rvn && !ffe && !ffs;
      check("west_re", bus.west_re, exp_re);
      check("north_re", bus.north_re, exp_re);
      check("east_we", bus.east_we, exp_we);
      check("south_we", bus.south_we, exp_we);
      if (exp_we) begin
        check("east_dat", bus.east_dat, exp_e);
        check("south_dat", bus.south_dat, exp_s);
      end
      check("res_valid", bus.res_valid, done);
      check("busy_run", bus.busy, 1'b1);
      if (bus.west_re) dut_pops++;
      if (done) begin
        check("res_data", bus.res_data, acc);
        check("pop_count", dut_pops, len);
        break;
      end
      exp_we = exp_re;
      if (exp_re) begin
        exp_e = qa.pop_front();
        exp_s = qb.pop_front();
        acc   = acc + prod(exp_e, exp_s);
        pops++;
        done  = (pops == len);
      end
      if (abort_after > 0 && pops == abort_after) return;
    end
    if (!done) check("tile_timeout", 1'b0, 1'b1);
    last_res  = bus.res_data;
    last_pops = dut_pops;

    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.res_ack  = 1'b0;
      bus.east_ff  = 1'b0;
      bus.south_ff = 1'b0;
      present_heads(1'b1, 1'b1);
      @(negedge clk);
      check("done_hold_valid", bus.res_valid, 1'b1);
      check("done_hold_data", bus.res_data, acc);
      check("done_no_pop", bus.west_re, 1'b0);
    end
    @(posedge clk); #1;
    bus.res_ack = 1'b1;
    @(negedge clk);
    check("ack_cycle_valid", bus.res_valid, 1'b1);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("post_ack_valid", bus.res_valid, 1'b0);
    check("post_ack_busy", bus.busy, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] a0, b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_data", bus.res_data, '0);
    check("rst_east_we", bus.east_we, 1'b0);
    check("rst_east_dat", bus.east_dat, '0);
    check("rst_south_dat", bus.south_dat, '0);
    rst_n = 1'b1;

    qa = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'd9};
    qb = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd9};
    run_tile(4, 0, 0);
    check("len4_result", last_res, 32'd70);

    qa = '{16'hFFFD, 16'h7FFF, 16'd1, 16'd1};
    qb = '{16'd4, 16'h7FFF, 16'd1, 16'd1};
    run_tile(2, 0, 0);
    check("signed_wrap", last_res, 32'h3FFE_FFF5);

    fill_random(5);
    run_tile(3, 2, 0);
    check("bp_pops", last_pops, 3);

    fill_random(6);
    run_tile(4, 3, 0);

    fill_random(2);
    run_tile(0, 0, 0);
    check("len0_result", last_res, '0);

    fill_random(7);
    run_tile(5, 0, 2);
    a0 = DW'($urandom);
    b0 = DW'($urandom);
    qa = '{a0, 16'd3, 16'd3};
    qb = '{b0, 16'd3, 16'd3};
    run_tile(1, 0, 0);
    check("abort_result", last_res, prod(a0, b0));
    check("abort_pops", last_pops, 1);

    fill_random(7);
    run_tile(5, 0, 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_re", bus.west_re, 1'b0);
    check("arst_east_we", bus.east_we, 1'b0);
    check("arst_south_we", bus.south_we, 1'b0);
    check("arst_east_dat", bus.east_dat, '0);
    check("arst_south_dat", bus.south_dat, '0);
    check("arst_res_data", bus.res_data, '0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk); #1;
    bus.res_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_busy", bus.busy, 1'b0);
    check("idle_ack_valid", bus.res_valid, 1'b0);

    fill_random(257);
    run_tile(255, 1, 0);
    check("len255_pops", last_pops, 255);

    for (int t = 0; t < 8; t++) begin
      int l;
      l = $urandom_range(1, 16);
      fill_random(l + 2);
      if ($urandom_range(0, 3) == 0 && l > 2) begin
        run_tile(l, 1, $urandom_range(1, l - 1));
        fill_random(l + 2);
      end
      run_tile(l, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/systolic_pe_mac.md
Name: systolic_pe_mac

Overview:
- Processing element that sits directly downstream of the west and north 16-bit operand FIFOs in the systolic array.
- Pops one operand pair per cycle when both FIFOs report valid and both downstream FIFOs have room.
- Forwards the operands unchanged to the east and south FIFOs.
- Accumulates the signed product over a programmable number of steps, then presents the 32-bit result on a hold-until-ack result port.

Parameters:
- DW, 16, operand width (west/north/east/south data).
- ACCW, 32, accumulator and result width; must be >= 2*DW.
- LENW, 8, width of the step-count input len.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latch len, clear accumulator and step counter, enter RUN
- len  in  LENW  number of MAC steps for this tile; sampled only on start
- west_rv  in  1  west FIFO read-valid
- west_dat  in  DW  west FIFO data (A operand)
- west_re  out  1  west FIFO read-enable (pop)
- north_rv  in  1  north FIFO read-valid
- north_dat  in  DW  north FIFO data (B operand)
- north_re  out  1  north FIFO read-enable (pop)
- east_ff  in  1  east FIFO full flag
- east_we  out  1  east FIFO write-enable
- east_dat  out  DW  A operand forwarded east
- south_ff  in  1  south FIFO full flag
- south_we  out  1  south FIFO write-enable
- south_dat  out  DW  B operand forwarded south
- busy  out  1  high in RUN or DONE
- res_valid  out  1  result available
- res_data  out  ACCW  accumulated result
- res_ack  in  1  result consumed

Behaviour:
- Reset: state=IDLE, acc=0, step counter=0, len latch=0, all outputs 0 (including east_dat/south_dat/res_data).
- States:
  - IDLE: start with len!=0 -> RUN; start with len==0 -> DONE with acc=0.
  - RUN: fire steps until step counter reaches len, then -> DONE on that same edge.
  - DONE: res_valid=1; res_ack -> IDLE; start -> restart.
- fire = (state==RUN) & west_rv & north_rv & ~east_ff & ~south_ff. Purely combinational.
- Pop: west_re = north_re = fire, same cycle. Never pop one FIFO without the other. No pop outside RUN.
- On the fire edge:
  - acc <= acc + sign_ext(west_dat*north_dat). Signed DW x DW product, sign-extended to ACCW, two's-complement wrap on overflow, no saturation.
  - step counter +1.
  - east_dat <= west_dat; south_dat <= north_dat.
- Forwarding: east_we/south_we registered = fire delayed 1 cycle, both asserted together. Data is held stable until the next fire.
- Result timing: the final fire edge updates acc and enters DONE, so res_valid rises the cycle after the last pop. res_data = acc, held stable while res_valid=1.
- res_ack:
  - Effective only while res_valid=1; it clears res_valid on the next edge.
  - res_ack in IDLE/RUN is ignored.
- busy = (state!=IDLE).
- start priority: start in any state (RUN mid-tile or DONE) aborts the current operation. acc=0, counter=0, len re-latched, res_valid=0, state per len rule. A fire in the same cycle as start is suppressed (no pop) because start wins.
- Stall: if any of rv low or ff high holds in RUN, no pop, no acc change, no forward write. State is unchanged indefinitely.
- Counter width LENW. len=2^LENW-1 must complete correctly with no wrap before compare.
- Reset mid-operation returns immediately to reset values. Pending forwarded writes are dropped.

Test Plan:
- len=4, A={1,2,3,4}, B={5,6,7,8}, FIFOs always ready -> 4 consecutive pops. east_dat sequence 1,2,3,4 and south_dat sequence 5,6,7,8, one cycle after each pop. res_valid the cycle after the 4th pop, res_data=70.
- Signed/wrap: len=2, A={-3,0x7FFF}, B={4,0x7FFF} -> res_data = -12 + 0x3FFF0001 = 0x3FFEFFF5.
- Backpressure: len=3, east_ff high for cycles 2-5 of RUN -> no pops or writes while high. The result is identical to the no-stall run, and each FIFO sees exactly 3 pops.
- Skewed arrival: north_rv low for the first 3 cycles while west_rv high -> west_re stays 0 until north_rv rises, then pops stay paired.
- len=0 start -> DONE next cycle, res_data=0, zero pops. res_ack -> IDLE, busy=0.
- Abort and reset: start re-issued after 2 of 5 steps with len=1 -> acc cleared, exactly 1 further pop, result = that single product. Then rst_n low mid-RUN -> all outputs 0 asynchronously.
